// File: rtl/detector_nota_pkg.sv
// rtl/detector_nota_pkg.sv - note codes, nominal half-periods and classifier for detector_nota
package detector_nota_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    DO   = 3'd1,
    RE   = 3'd2,
    MI   = 3'd3,
    FA   = 3'd4,
    SI   = 3'd5
  } note_e;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic  low;
    note_e code;
  } class_t;

  localparam int REF_CLK_HZ = 50_000_000;

  // Half-periods in cycles at REF_CLK_HZ, shared with the melody generators
  localparam int HP_DO_HI = 47_779;
  localparam int HP_RE_HI = 42_567;
  localparam int HP_MI_HI = 37_923;
  localparam int HP_FA_HI = 35_794;
  localparam int HP_SI_HI = 50_620;
  localparam int HP_DO_LO = 95_557;
  localparam int HP_RE_LO = 85_132;
  localparam int HP_MI_LO = 75_844;
  localparam int HP_FA_LO = 71_588;
  localparam int HP_SI_LO = 101_239;

  localparam int HP_TABLE [10] = '{HP_DO_HI, HP_RE_HI, HP_MI_HI, HP_FA_HI, HP_SI_HI,
                                   HP_DO_LO, HP_RE_LO, HP_MI_LO, HP_FA_LO, HP_SI_LO};

  // Exact at REF_CLK_HZ; other rates get a proportionally scaled (floored) table
  function automatic int scale_hp(int hp, int clk_hz);
    return int'((longint'(hp) * longint'(clk_hz)) / longint'(REF_CLK_HZ));
  endfunction

  function automatic class_t classify(logic [19:0] cnt, int tol, int clk_hz);
    class_t r;
    int     d;
    r.low  = 1'b0;
    r.code = NONE;
    for (int i = 0; i < 10; i++) begin
      d = int'(cnt) - scale_hp(HP_TABLE[i], clk_hz);
      if (d < 0) d = -d;
      if (d <= tol) begin
        r.code = note_e'(3'(i % 5 + 1));
        r.low  = (i >= 5);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/detector_nota_sincronizador_flanco.sv
// rtl/detector_nota_sincronizador_flanco.sv - 2-FF synchronizer with registered dual-edge pulse
module sincronizador_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_det
);

  // sh[1:0] synchronize, sh[2] holds the previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= 3'b000;
      edge_det <= 1'b0;
    end else begin
      sh       <= {sh[1:0], din};
      edge_det <= sh[1] ^ sh[2];
    end
  end

endmodule

// File: rtl/detector_nota.sv
// rtl/detector_nota.sv - half-period tone detector; DETECTOR_NOTA_STATS_EN adds lock_count/stats_clr
module detector_nota
  import detector_nota_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TOL     = 512,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 1_048_575
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tone_in,
`ifdef DETECTOR_NOTA_STATS_EN
  input  logic       stats_clr,
  output logic [7:0] lock_count,
`endif
  output logic [2:0] note_code,
  output logic       octave_low,
  output logic       note_valid,
  output logic       tone_present,
  output logic       silence_evt
);

  logic        edge_det;
  state_e      state;
  logic [19:0] count;
  note_e       cand_code;
  logic        cand_low;
  logic [2:0]  match_cnt;
  class_t      meas;
  logic        same_cand;
  logic        same_locked;
  logic        timeout_hit;
  logic [2:0]  next_match;

  sincronizador_flanco u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (tone_in),
    .edge_det (edge_det)
  );

  assign meas        = classify(count, TOL, CLK_HZ);
  assign same_cand   = (meas.code == cand_code) && (meas.low == cand_low);
  assign same_locked = (3'(meas.code) == note_code) && (meas.low == octave_low);
  assign timeout_hit = (count == 20'(TIMEOUT));

  always_comb begin
    next_match = 3'd0;
    if (meas.code == NONE)       next_match = 3'd0;
    else if (!same_cand)         next_match = 3'd1;
    else if (match_cnt != 3'd7)  next_match = match_cnt + 3'd1;
    else                         next_match = match_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SILENT;
      count        <= 20'd0;
      cand_code    <= NONE;
      cand_low     <= 1'b0;
      match_cnt    <= 3'd0;
      note_code    <= 3'd0;
      octave_low   <= 1'b0;
      note_valid   <= 1'b0;
      tone_present <= 1'b0;
      silence_evt  <= 1'b0;
    end else begin
      note_valid  <= 1'b0;
      silence_evt <= 1'b0;
      if (!enable) begin
        state        <= ST_SILENT;
        count        <= 20'd0;
        cand_code    <= NONE;
        cand_low     <= 1'b0;
        match_cnt    <= 3'd0;
        note_code    <= 3'd0;
        octave_low   <= 1'b0;
        tone_present <= 1'b0;
      end else begin
        case (state)
          ST_SILENT: begin
            // First edge only opens the measurement window
            if (edge_det) begin
              state        <= ST_ARMED;
              count        <= 20'd1;
              cand_code    <= NONE;
              cand_low     <= 1'b0;
              match_cnt    <= 3'd0;
              tone_present <= 1'b1;
            end
          end
          ST_ARMED, ST_LOCKED: begin
            if (edge_det) begin
              count <= 20'd1;
              if (state == ST_ARMED) begin
                cand_code <= meas.code;
                cand_low  <= meas.low;
                match_cnt <= next_match;
                if (meas.code != NONE && int'(next_match) >= CONFIRM) begin
                  state      <= ST_LOCKED;
                  note_code  <= meas.code;
                  octave_low <= meas.low;
                  note_valid <= 1'b1;
                end
              end else if (!same_locked) begin
                state     <= ST_ARMED;
                cand_code <= meas.code;
                cand_low  <= meas.low;
                match_cnt <= (meas.code == NONE) ? 3'd0 : 3'd1;
              end
            end else if (timeout_hit) begin
              silence_evt  <= (state == ST_LOCKED);
              state        <= ST_SILENT;
              count        <= 20'd0;
              cand_code    <= NONE;
              cand_low     <= 1'b0;
              match_cnt    <= 3'd0;
              note_code    <= 3'd0;
              octave_low   <= 1'b0;
              tone_present <= 1'b0;
            end else begin
              count <= count + 20'd1;
            end
          end
          default: state <= ST_SILENT;
        endcase
      end
    end
  end

`ifdef DETECTOR_NOTA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                lock_count <= 8'd0;
    else if (stats_clr)                        lock_count <= 8'd0;
    else if (note_valid && lock_count != 8'hFF) lock_count <= lock_count + 8'd1;
  end
`endif

endmodule
